imem_boot_loader: RTL and testbench

//   Boot-time program loader sitting directly upstream of the cpu core: accepts a stream
//   of 32-bit instruction words, writes them into instruction memory via a write port,
//   and holds the core in reset until the image is fully written plus a guard interval.

---
 rtl/imem_boot_loader.sv | 139 +++++++++++++
 tb/tb_imem_boot_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot-time instruction-memory loader: streams words into imem through a write port and
// holds the cpu core in reset until the image is written plus a guard interval.
module imem_boot_loader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count,
  output logic [1:0]        state_dbg
);

  // Stream handshake: a beat transfers on a rising edge where s_valid && s_ready;
  // s_ready is high exactly while in LOAD and does not depend on s_valid.

  localparam int HC_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [ADDR_W:0] DEPTH_P   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_MAX   = '1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              accept;
  logic              overflow;

  assign accept   = s_valid && (state_q == ST_LOAD);
  // Pointer is one bit wider than the address and saturates at DEPTH, so it never wraps.
  assign overflow = (ptr_q >= DEPTH_P);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = {1'b0, load_base};
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (overflow) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q[ADDR_W-1:0];
            wdata_d = s_data;
            ptr_d   = ptr_q + 1'b1;
          end
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (s_last) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = ST_RUN;
        else hold_d = hold_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered from the next state so the core is released exactly on entry to RUN.
    cpu_reset_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      hold_q      <= '0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      hold_q      <= hold_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign s_ready      = (state_q == ST_LOAD);
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_HOLD);
  assign done         = (state_q == ST_RUN);
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign err_overflow = err_q;
  assign word_count   = cnt_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: per-cycle vector table for the basic load/reload flow,
// plus directed sequences for gapped streams, overflow and asynchronous reset.
module tb_imem_boot_loader;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 8;
  localparam int DEPTH    = 256;
  localparam int RST_HOLD = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_start = 1'b0;
  logic [ADDR_W-1:0] load_base = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              err_overflow;
  logic [ADDR_W:0]   word_count;
  logic [1:0]        state_dbg;

  imem_boot_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_base(load_base),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err_overflow(err_overflow),
    .word_count(word_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int inv_bad  = 0;
  logic [55:0] exp_q[$];
  logic [55:0] obs_q[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) obs_q.push_back({16'(cyc), imem_addr, imem_wdata});
    if (reset === 1'b1 && busy === 1'b1 && cpu_reset !== 1'b1) inv_bad++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {9'd0, imem_we, imem_addr, imem_wdata, s_ready, cpu_reset, done, busy,
            err_overflow, word_count};
  endfunction

  localparam logic [63:0] RESET_OUTS = {9'd0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0,
                                        1'b0, 9'd0};

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({tag, "_write"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  // Waits (bounded) for RUN and checks it arrives RST_HOLD+1 cycles after the last accept.
  task automatic wait_run(input int last_acc, input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_run_reached"}, 64'(done), 64'd1);
    check({tag, "_run_latency"}, 64'(cyc), 64'(last_acc + 1 + RST_HOLD));
    check({tag, "_cpu_reset_low"}, 64'(cpu_reset), 64'd0);
  endtask

  // ---------------- driver ----------------
  task automatic run_load(input logic [7:0] base, input int n, input int gap,
                          input logic [31:0] seed, input string tag);
    int p;
    int last_acc;
    p = int'(base);
    last_acc = 0;
    @(negedge clk);
    load_start = 1'b1;
    load_base  = base;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          s_valid = 1'b0;
          s_data  = 32'hBAD0_0000 + 32'(g);
          s_last  = 1'b1;
          @(negedge clk);
        end
      end
      s_valid = 1'b1;
      s_data  = seed + 32'(i);
      s_last  = (i == n - 1);
      check({tag, "_ready_on_beat"}, 64'(s_ready), 64'd1);
      if (p < DEPTH) exp_q.push_back({16'(cyc + 1), 8'(p), seed + 32'(i)});
      p++;
      last_acc = cyc;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    wait_run(last_acc, tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ls;
    logic [7:0]  base;
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic        rdy;
    logic        cr;
    logic        dn;
    logic        bsy;
    logic        err;
    logic [8:0]  cnt;
  } vec_t;

  function automatic vec_t mk(logic ls, logic [7:0] base, logic v, logic [31:0] d, logic l,
                              logic we, logic [7:0] addr, logic [31:0] wd, logic rdy,
                              logic cr, logic dn, logic bsy, logic err, logic [8:0] cnt);
    vec_t r;
    r.ls = ls; r.base = base; r.v = v; r.d = d; r.l = l;
    r.we = we; r.addr = addr; r.wd = wd; r.rdy = rdy; r.cr = cr;
    r.dn = dn; r.bsy = bsy; r.err = err; r.cnt = cnt;
    return r;
  endfunction

  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h0010_0113;
  localparam logic [31:0] W2 = 32'h0020_0193;
  localparam logic [31:0] W3 = 32'h0030_0213;
  localparam logic [31:0] WA = 32'h1234_5678;
  localparam logic [31:0] WB = 32'h9ABC_DEF0;

  vec_t vt[18];

  initial begin : main
    int bad;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check("reset_outs_async", outs(), RESET_OUTS);
    check("reset_state", 64'(state_dbg), 64'd0);
    repeat (3) @(negedge clk);
    check("reset_outs_held", outs(), RESET_OUTS);
    reset = 1'b1;

    // Test 1: idle without load_start
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_reset !== 1'b1 || done !== 1'b0) bad++;
    end
    check("idle_cpu_reset_done", 64'(bad), 64'd0);
    check("idle_no_writes", 64'(obs_q.size()), 64'd0);

    // Tests 2 and 5: one cycle per vector; outputs expected while the inputs are applied
    vt[0]  = mk(1, 8'h00, 0, 32'h0,  0, 0, 8'h00, 32'h0, 0, 1, 0, 0, 0, 9'd0);
    vt[1]  = mk(0, 8'h00, 1, W0,     0, 0, 8'h00, 32'h0, 1, 1, 0, 1, 0, 9'd0);
    vt[2]  = mk(0, 8'h00, 1, W1,     0, 1, 8'h00, W0,    1, 1, 0, 1, 0, 9'd1);
    vt[3]  = mk(0, 8'h00, 1, W2,     0, 1, 8'h01, W1,    1, 1, 0, 1, 0, 9'd2);
    vt[4]  = mk(0, 8'h00, 1, W3,     1, 1, 8'h02, W2,    1, 1, 0, 1, 0, 9'd3);
    vt[5]  = mk(0, 8'h00, 0, 32'h0,  0, 1, 8'h03, W3,    0, 1, 0, 1, 0, 9'd4);
    vt[6]  = mk(0, 8'h00, 1, 32'hDEAD_BEEF, 1, 0, 8'h03, W3, 0, 1, 0, 1, 0, 9'd4);
    vt[7]  = mk(0, 8'h00, 0, 32'h0,  0, 0, 8'h03, W3,    0, 1, 0, 1, 0, 9'd4);
    vt[8]  = mk(0, 8'h00, 0, 32'h0,  0, 0, 8'h03, W3,    0, 1, 0, 1, 0, 9'd4);
    vt[9]  = mk(0, 8'h00, 0, 32'h0,  0, 0, 8'h03, W3,    0, 0, 1, 0, 0, 9'd4);
    vt[10] = mk(1, 8'h20, 0, 32'h0,  0, 0, 8'h03, W3,    0, 0, 1, 0, 0, 9'd4);
    vt[11] = mk(0, 8'h00, 1, WA,     0, 0, 8'h03, W3,    1, 1, 0, 1, 0, 9'd0);
    vt[12] = mk(1, 8'h50, 1, WB,     1, 1, 8'h20, WA,    1, 1, 0, 1, 0, 9'd1);
    vt[13] = mk(0, 8'h00, 0, 32'h0,  0, 1, 8'h21, WB,    0, 1, 0, 1, 0, 9'd2);
    vt[14] = mk(1, 8'h50, 0, 32'h0,  0, 0, 8'h21, WB,    0, 1, 0, 1, 0, 9'd2);
    vt[15] = mk(0, 8'h00, 0, 32'h0,  0, 0, 8'h21, WB,    0, 1, 0, 1, 0, 9'd2);
    vt[16] = mk(0, 8'h00, 0, 32'h0,  0, 0, 8'h21, WB,    0, 1, 0, 1, 0, 9'd2);
    vt[17] = mk(0, 8'h00, 0, 32'h0,  0, 0, 8'h21, WB,    0, 0, 1, 0, 0, 9'd2);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(),
            {9'd0, vt[i].we, vt[i].addr, vt[i].wd, vt[i].rdy, vt[i].cr, vt[i].dn,
             vt[i].bsy, vt[i].err, vt[i].cnt});
      load_start = vt[i].ls;
      load_base  = vt[i].base;
      s_valid    = vt[i].v;
      s_data     = vt[i].d;
      s_last     = vt[i].l;
    end
    @(negedge clk);
    load_start = 1'b0;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    s_data     = '0;
    obs_q.delete();

    // Test 3: gapped stream from 0x10
    run_load(8'h10, 3, 1, 32'hA5A5_0000, "gap");
    check("gap_count", 64'(word_count), 64'd3);
    check("gap_err", 64'(err_overflow), 64'd0);
    compare_writes("gap");

    // Test 4: image runs past the end of imem
    run_load(8'(DEPTH - 2), 4, 0, 32'hC0DE_0000, "ovf");
    check("ovf_err", 64'(err_overflow), 64'd1);
    check("ovf_count", 64'(word_count), 64'd4);
    compare_writes("ovf");
    @(negedge clk);
    load_start = 1'b1;
    load_base  = 8'h00;
    @(negedge clk);
    load_start = 1'b0;
    check("reload_err_cleared", 64'(err_overflow), 64'd0);
    check("reload_cpu_reset", 64'(cpu_reset), 64'd1);
    check("reload_count_zero", 64'(word_count), 64'd0);
    s_valid = 1'b1;
    s_data  = 32'h0000_0013;
    s_last  = 1'b1;
    exp_q.push_back({16'(cyc + 1), 8'h00, 32'h0000_0013});
    bad = cyc;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    wait_run(bad, "reload");
    compare_writes("reload");

    // Test 6: asynchronous reset mid-LOAD with a write in flight
    @(negedge clk);
    load_start = 1'b1;
    load_base  = 8'h40;
    @(negedge clk);
    load_start = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h1111_1111;
    @(negedge clk);
    s_data  = 32'h2222_2222;
    @(negedge clk);
    s_valid = 1'b0;
    check("mid_load_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1 check("async_reset_outs", outs(), RESET_OUTS);
    check("async_reset_state", 64'(state_dbg), 64'd0);
    obs_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_state", 64'(state_dbg), 64'd0);
    check("post_reset_ready", 64'(s_ready), 64'd0);
    check("post_reset_cpu_reset", 64'(cpu_reset), 64'd1);
    check("post_reset_no_writes", 64'(obs_q.size()), 64'd0);

    check("busy_implies_cpu_reset", 64'(inv_bad), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
